// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and
// fetch geometry constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [63:0] RESET_PC    = 64'h0;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC calculation, shared by fetch and the branch unit.
// The target is pc+imm_branch when taken, otherwise the sequential pc+4.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int xlen = 64
) (
  input  logic [xlen-1:0] pc,
  input  logic            branch_taken,
  input  logic [xlen-1:0] imm_branch,
  output logic [xlen-1:0] next_pc,
  output logic            misaligned
);

  // Modulo-2^xlen arithmetic; wrap-around is intentional and silent.
  assign next_pc    = pc + (branch_taken ? imm_branch : xlen'(INSTR_BYTES));
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory via req/ack
// and hands one instruction at a time to decode under valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              xlen     = 64,
  parameter logic [xlen-1:0] reset_pc = xlen'(RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [xlen-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [xlen-1:0] pc,
  input  logic            branch_taken,
  input  logic [xlen-1:0] imm_branch,
  output logic            misaligned,
  output logic [xlen-1:0] fetch_count,
  output fetch_state_t    state
);

  // Handshake: decode takes instr on a cycle where instr_valid and
  // instr_ready are both high; instr_valid never drops until that happens,
  // and instr/pc do not change while it is high. instr_ready alone is inert.

  fetch_state_t    state_d;
  logic            armed;
  logic            accept;
  logic [xlen-1:0] next_pc;
  logic            next_misaligned;

  next_pc_calc #(.xlen(xlen)) u_next_pc (
    .pc           (pc),
    .branch_taken (branch_taken),
    .imm_branch   (imm_branch),
    .next_pc      (next_pc),
    .misaligned   (next_misaligned)
  );

  assign imem_addr = pc;

  always_comb begin
    state_d     = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      // The first edge after reset release only arms the FSM, so the first
      // request appears after the second edge.
      IDLE: if (armed) state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        accept      = instr_ready;
        if (instr_ready) state_d = next_misaligned ? HALT : FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      pc          <= reset_pc;
      instr       <= '0;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_d;
      armed <= 1'b1;
      if (state == FETCH && imem_ack) instr <= imem_rdata;
      if (accept) begin
        // A faulting target is still loaded into pc for debug visibility.
        pc          <= next_pc;
        fetch_count <= fetch_count + xlen'(1);
        if (next_misaligned) misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [63:0] pc;
  logic        branch_taken = 1'b0;
  logic [63:0] imm_branch = '0;
  logic        misaligned;
  logic [63:0] fetch_count;
  fetch_state_t state;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.xlen(64), .reset_pc(64'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc           (pc),
    .branch_taken (branch_taken),
    .imm_branch   (imm_branch),
    .misaligned   (misaligned),
    .fetch_count  (fetch_count),
    .state        (state)
  );

  // Clock/reset block: inputs driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: expects a pending request; acks after lat cycles.
  task automatic serve(input int lat, input logic [63:0] addr, input logic [31:0] data);
    for (int i = 0; i < lat - 1; i++) begin
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, addr);
      chk("wait_valid", instr_valid, 1'b0);
      @(negedge clk);
    end
    chk("req", imem_req, 1'b1);
    chk("addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_instr", instr, {32'h0, data});
    chk("hold_req", imem_req, 1'b0);
  endtask

  task automatic accept(input logic br, input logic [63:0] imm);
    instr_ready  = 1'b1;
    branch_taken = br;
    imm_branch   = imm;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    imm_branch   = 64'h0;
  endtask

  task automatic release_reset();
    rst = 1'b0;
    @(negedge clk);
    chk("arm_req", imem_req, 1'b0);
    chk("arm_state", state, IDLE);
    @(negedge clk);
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 64'h0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", instr, 64'h0);
    chk("rst_mis", misaligned, 1'b0);
    chk("rst_cnt", fetch_count, 64'h0);
    chk("rst_state", state, IDLE);
    release_reset();

    // Sequential fetch, 1-cycle memory
    for (int i = 0; i < 4; i++) begin
      serve(1, 64'(4 * i), 32'h0000_0013);
      chk("seq_pc", pc, 64'(4 * i));
      accept(1'b0, 64'h0);
    end
    chk("seq_cnt", fetch_count, 64'd4);
    chk("seq_pc16", pc, 64'h10);

    // Decode stall of 5 cycles, then accept with a branch to 0x100
    serve(1, 64'h10, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_instr", instr, 64'hDEAD_BEEF);
      chk("stall_pc", pc, 64'h10);
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_req", imem_req, 1'b0);
      chk("stall_cnt", fetch_count, 64'd4);
    end
    accept(1'b1, 64'hF0);
    chk("br_pc100", pc, 64'h100);
    chk("br_cnt", fetch_count, 64'd5);

    // Backward taken branch: 0x100 - 8
    serve(1, 64'h100, 32'h0000_0063);
    accept(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("back_addr", imem_addr, 64'hF8);
    chk("back_req", imem_req, 1'b1);

    // 7-cycle memory latency, then a spurious ack while holding
    serve(7, 64'hF8, 32'hA5A5_0001);
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("spur_instr", instr, 64'hA5A5_0001);
    chk("spur_state", state, HOLD);
    accept(1'b1, 64'h8);
    chk("lat_pc", pc, 64'h100);
    chk("lat_cnt", fetch_count, 64'd7);

    // Misaligned taken branch halts the fetch unit
    serve(1, 64'h100, 32'h0000_0063);
    accept(1'b1, 64'h6);
    chk("mis_flag", misaligned, 1'b1);
    chk("mis_pc", pc, 64'h106);
    chk("mis_state", state, HALT);
    chk("mis_cnt", fetch_count, 64'd8);
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_req", imem_req, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_state", state, HALT);
      chk("halt_cnt", fetch_count, 64'd8);
    end
    instr_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("clr_mis", misaligned, 1'b0);
    chk("clr_cnt", fetch_count, 64'd0);
    release_reset();

    // Asynchronous reset mid-FETCH, between clock edges
    #2 rst = 1'b1;
    #1;
    chk("async_req", imem_req, 1'b0);
    chk("async_pc", pc, 64'h0);
    chk("async_state", state, IDLE);
    @(negedge clk);
    release_reset();

    // Wrap: branch to the top word, then sequential fetch wraps to 0
    serve(1, 64'h0, 32'h0000_0013);
    accept(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    serve(1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013);
    accept(1'b0, 64'h0);
    chk("wrap_pc", pc, 64'h0);
    chk("wrap_req", imem_req, 1'b1);
    chk("wrap_mis", misaligned, 1'b0);
    chk("wrap_cnt", fetch_count, 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
